cory_decimate: RTL and testbench

- Stream filter on a valid/ready channel: periodically drops beats (skip S, keep K, repeat) and force-drops beats while an external ignore is high.
- Dropped beats are always consumed upstream and never reach downstream.
- Counts dropped beats in a saturating status counter and flags each completed period.
- Sits between a producer and a consumer anywhere a channel needs decimation or muting, e.g. sample thinning or debug tap gating.

---
 rtl/cory_decimate_sat_cnt.sv | 25 ++
 rtl/cory_decimate.sv | 78 +++++++
 tb/tb_cory_decimate.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/cory_decimate_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// A clear in the same cycle as an increment leaves the count at zero.
module cory_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/cory_decimate.sv
// Valid/ready decimator: drops S beats, then passes K beats, and repeats.
// External ignore force-drops beats; dropped beats are consumed upstream and counted.
module cory_decimate #(
  parameter int N  = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_a_v,
  input  logic [N-1:0]  i_a_d,
  output logic          o_a_r,
  input  logic          i_a_ignore,
  input  logic          i_cfg_en,
  input  logic [CW-1:0] i_cfg_skip,
  input  logic [CW-1:0] i_cfg_keep,
  output logic          o_z_v,
  output logic [N-1:0]  o_z_d,
  input  logic          i_z_r,
  input  logic          i_drop_clr,
  output logic [CW-1:0] o_drop_cnt,
  output logic          o_wrap
);

  localparam int PW = CW + 1;

  logic [PW-1:0] r_pos;
  logic          r_wrap;
  logic [PW-1:0] w_skip;
  logic [PW-1:0] w_period;
  logic [PW-1:0] w_last;
  logic          w_drop;
  logic          w_acc;
  logic          w_adv;

  // One extra bit so S+K never overflows; P=0 means the pattern is disabled.
  assign w_skip   = {1'b0, i_cfg_skip};
  assign w_period = w_skip + {1'b0, i_cfg_keep};
  assign w_last   = w_period - PW'(1);

  assign w_drop = i_a_ignore | (i_cfg_en & (r_pos < w_skip));

  assign o_z_v = ~reset & i_a_v & ~w_drop;
  assign o_z_d = (reset | w_drop) ? '0 : i_a_d;
  assign o_a_r = ~reset & (w_drop | i_z_r);

  assign w_acc = i_a_v & o_a_r;
  assign w_adv = w_acc & ~i_a_ignore & i_cfg_en & (w_period != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pos  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (!i_cfg_en) begin
        r_pos <= '0;
      end else if (w_adv) begin
        if (r_pos == w_last) begin
          r_pos  <= '0;
          r_wrap <= 1'b1;
        end else begin
          r_pos <= r_pos + PW'(1);
        end
      end
    end
  end

  assign o_wrap = r_wrap;

  cory_sat_cnt #(.W(CW)) u_drop_cnt (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_acc & w_drop),
    .i_clr (i_drop_clr),
    .o_cnt (o_drop_cnt)
  );

endmodule

// File: tb/tb_cory_decimate.sv
// Bench for cory_decimate: table of decimation scenarios with a data scoreboard,
// plus hand sequences for mid-stream reset and counter saturation on a narrow instance.
module tb_cory_decimate;

  localparam int N = 8;

  typedef struct {
    string       name;
    logic        en;
    logic [7:0]  s;
    logic [7:0]  k;
    int          n;
    bit          tog;
    logic [15:0] ign;
    logic [15:0] kept;
    logic [15:0] wrap;
    logic [7:0]  drops;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_a_v, i_a_ignore, i_cfg_en, i_z_r, i_drop_clr;
  logic [N-1:0] i_a_d;
  logic [7:0]   i_cfg_skip, i_cfg_keep;
  logic         o_a_r, o_z_v, o_wrap;
  logic [N-1:0] o_z_d;
  logic [7:0]   o_drop_cnt;

  logic         b_a_v, b_a_ignore, b_en, b_z_r, b_clr;
  logic [N-1:0] b_a_d;
  logic [1:0]   b_skip, b_keep;
  logic         b_a_r, b_z_v, b_wrap;
  logic [N-1:0] b_z_d;
  logic [1:0]   b_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [N-1:0] sb[$];
  vec_t tbl[9];

  always #5 clk = ~clk;

  cory_decimate #(.N(N), .CW(8)) u_dut (
    .clk(clk), .reset(reset), .i_a_v(i_a_v), .i_a_d(i_a_d), .o_a_r(o_a_r),
    .i_a_ignore(i_a_ignore), .i_cfg_en(i_cfg_en), .i_cfg_skip(i_cfg_skip),
    .i_cfg_keep(i_cfg_keep), .o_z_v(o_z_v), .o_z_d(o_z_d), .i_z_r(i_z_r),
    .i_drop_clr(i_drop_clr), .o_drop_cnt(o_drop_cnt), .o_wrap(o_wrap)
  );

  cory_decimate #(.N(N), .CW(2)) u_dut2 (
    .clk(clk), .reset(reset), .i_a_v(b_a_v), .i_a_d(b_a_d), .o_a_r(b_a_r),
    .i_a_ignore(b_a_ignore), .i_cfg_en(b_en), .i_cfg_skip(b_skip),
    .i_cfg_keep(b_keep), .o_z_v(b_z_v), .o_z_d(b_z_d), .i_z_r(b_z_r),
    .i_drop_clr(b_clr), .o_drop_cnt(b_cnt), .o_wrap(b_wrap)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic en, input logic [7:0] s,
                              input logic [7:0] k, input int n, input bit tog,
                              input logic [15:0] ign, input logic [15:0] kept,
                              input logic [15:0] wrap, input logic [7:0] drops);
    vec_t v;
    v.name = nm; v.en = en; v.s = s; v.k = k; v.n = n; v.tog = tog;
    v.ign = ign; v.kept = kept; v.wrap = wrap; v.drops = drops;
    return v;
  endfunction

  task automatic setup(input vec_t v);
    i_a_v = 1'b0; i_a_ignore = 1'b0; i_cfg_en = 1'b0; i_drop_clr = 1'b1; i_z_r = 1'b1;
    i_cfg_skip = v.s; i_cfg_keep = v.k;
    @(posedge clk); #1;
    i_drop_clr = 1'b0; i_cfg_en = v.en;
  endtask

  task automatic run(input vec_t v, input int idx, input bit do_setup);
    logic [N-1:0] exp_d;
    bit done;
    if (do_setup) setup(v);
    for (int b = 0; b < v.n; b++) begin
      i_a_v = 1'b1;
      i_a_ignore = v.ign[b];
      i_a_d = N'(b + 16 * idx);
      if (v.kept[b]) sb.push_back(i_a_d);
      done = 1'b0;
      for (int c = 0; c < 16 && !done; c++) begin
        i_z_r = v.tog ? cyc[0] : 1'b1;
        @(negedge clk);
        if (o_z_v && i_z_r) begin
          if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s_extra_beat beat=%0d actual=%0h required=none", v.name, b, o_z_d);
          end else begin
            exp_d = sb.pop_front();
            chk($sformatf("%s_data_b%0d", v.name, b), o_z_d, exp_d);
          end
        end
        if (v.kept[b]) begin
          chk($sformatf("%s_zv_b%0d", v.name, b), o_z_v, 1);
          chk($sformatf("%s_ar_b%0d", v.name, b), o_a_r, i_z_r);
        end else begin
          chk($sformatf("%s_zv_drop_b%0d", v.name, b), o_z_v, 0);
          chk($sformatf("%s_zd_drop_b%0d", v.name, b), o_z_d, 0);
          chk($sformatf("%s_ar_drop_b%0d", v.name, b), o_a_r, 1);
        end
        done = i_a_v && o_a_r;
        @(posedge clk); #1;
        cyc++;
      end
      if (!done) begin
        checks++; failures++;
        $display("FAIL %s_timeout beat=%0d actual=not_accepted required=accepted", v.name, b);
      end
      chk($sformatf("%s_wrap_b%0d", v.name, b), o_wrap, v.wrap[b]);
    end
    i_a_v = 1'b0; i_a_ignore = 1'b0; i_z_r = 1'b1;
    chk($sformatf("%s_sb_empty", v.name), sb.size(), 0);
    chk($sformatf("%s_drop_cnt", v.name), o_drop_cnt, v.drops);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = mk("base",  1, 2, 3, 10, 0, 16'h0000, 16'h039C, 16'h0210, 4);
    tbl[1] = mk("bp",    1, 2, 3, 10, 1, 16'h0000, 16'h039C, 16'h0210, 4);
    tbl[2] = mk("ign",   1, 1, 1,  5, 0, 16'h0007, 16'h0010, 16'h0010, 4);
    tbl[3] = mk("p0",    1, 0, 0,  6, 0, 16'h0000, 16'h003F, 16'h0000, 0);
    tbl[4] = mk("off",   0, 3, 2,  6, 1, 16'h0000, 16'h003F, 16'h0000, 0);
    tbl[5] = mk("s0k2",  1, 0, 2,  5, 0, 16'h0000, 16'h001F, 16'h000A, 0);
    tbl[6] = mk("k0s2",  1, 2, 0,  4, 0, 16'h0000, 16'h0000, 16'h000A, 4);
    tbl[7] = mk("rstA",  1, 2, 2,  3, 0, 16'h0000, 16'h0004, 16'h0000, 2);
    tbl[8] = mk("rstB",  1, 2, 2,  4, 0, 16'h0000, 16'h000C, 16'h0008, 2);

    reset = 1'b1;
    i_a_v = 1'b1; i_a_d = 8'h5A; i_a_ignore = 1'b0; i_cfg_en = 1'b0;
    i_cfg_skip = '0; i_cfg_keep = '0; i_z_r = 1'b1; i_drop_clr = 1'b0;
    b_a_v = 1'b0; b_a_d = '0; b_a_ignore = 1'b0; b_en = 1'b0;
    b_skip = '0; b_keep = '0; b_z_r = 1'b1; b_clr = 1'b0;

    repeat (2) begin
      @(negedge clk);
      chk("rst_zv", o_z_v, 0);
      chk("rst_ar", o_a_r, 0);
      chk("rst_zd", o_z_d, 0);
      @(posedge clk); #1;
    end
    reset = 1'b0; i_a_v = 1'b0;
    chk("rst_drop_cnt", o_drop_cnt, 0);
    chk("rst_wrap", o_wrap, 0);
    chk("rst_b_cnt", b_cnt, 0);

    for (int t = 0; t < 8; t++) run(tbl[t], t, 1'b1);

    // Mid-pattern reset with a beat pending: nothing accepted, pattern restarts.
    i_a_v = 1'b1; i_a_d = 8'hAA; i_z_r = 1'b1; reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("midrst_zv", o_z_v, 0);
      chk("midrst_ar", o_a_r, 0);
      chk("midrst_zd", o_z_d, 0);
      @(posedge clk); #1;
    end
    reset = 1'b0; i_a_v = 1'b0;
    chk("midrst_drop_cnt", o_drop_cnt, 0);
    chk("midrst_wrap", o_wrap, 0);
    run(tbl[8], 8, 1'b0);

    // Narrow counter: K=0, S=1 drops every beat and saturates at 3.
    b_skip = 2'd1; b_keep = 2'd0;
    @(posedge clk); #1;
    b_en = 1'b1; b_a_v = 1'b1;
    for (int k = 0; k < 6; k++) begin
      b_a_d = N'(k);
      @(negedge clk);
      chk($sformatf("sat_ar_%0d", k), b_a_r, 1);
      chk($sformatf("sat_zv_%0d", k), b_z_v, 0);
      @(posedge clk); #1;
      chk($sformatf("sat_cnt_%0d", k), b_cnt, (k + 1 > 3) ? 3 : k + 1);
      chk($sformatf("sat_wrap_%0d", k), b_wrap, 1);
    end
    b_clr = 1'b1;
    @(posedge clk); #1;
    chk("clr_wins", b_cnt, 0);
    b_clr = 1'b0;
    @(posedge clk); #1;
    chk("cnt_after_clr", b_cnt, 1);
    b_a_v = 1'b0; b_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
